// File: rtl/xnor_gate_pkg.sv
// Shared constants, types and helpers for the registered bitwise XNOR unit.
package xnor_gate_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;

    // Bits needed to hold a count in the range 0..width.
    function automatic int unsigned cnt_w(input int unsigned width);
        return 32'($clog2(width + 1));
    endfunction

    // Occupancy of the single-entry output stage.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

endpackage

// File: rtl/xnor_gate_popcount.sv
// Combinational adder-tree bit count; recurses by halving until single bits remain.
module xnor_gate_popcount
    import xnor_gate_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]          bits,
    output logic [cnt_w(WIDTH)-1:0]   count
);

    localparam int unsigned CW = cnt_w(WIDTH);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign count = bits;
        end else begin : g_node
            localparam int unsigned LW = WIDTH / 2;
            localparam int unsigned HW = WIDTH - LW;

            logic [cnt_w(LW)-1:0] lo_cnt;
            logic [cnt_w(HW)-1:0] hi_cnt;

            xnor_gate_popcount #(.WIDTH(LW)) u_lo (
                .bits  (bits[LW-1:0]),
                .count (lo_cnt)
            );

            xnor_gate_popcount #(.WIDTH(HW)) u_hi (
                .bits  (bits[WIDTH-1:LW]),
                .count (hi_cnt)
            );

            assign count = CW'(lo_cnt) + CW'(hi_cnt);
        end
    endgenerate

endmodule

// File: rtl/xnor_gate_unit.sv
// Registered bitwise XNOR stage with valid/ready on both sides and an all-equal flag.
// Define XNOR_GATE_MISMATCH_CNT_EN to register a popcount of differing bits on mismatch_cnt.
module xnor_gate_unit
    import xnor_gate_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in1,
    input  logic [WIDTH-1:0]          in2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out1,
    output logic                      eq_all,
    output logic [cnt_w(WIDTH)-1:0]   mismatch_cnt
);

    localparam int unsigned CNT_W = cnt_w(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] out1;
        logic             eq_all;
        logic [CNT_W-1:0] mismatch_cnt;
    } result_t;

    stage_e  state, state_nxt;
    result_t res, res_nxt;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] same;
    logic [CNT_W-1:0] diff_cnt;
    logic             accept;
    logic             consume;

    assign diff = in1 ^ in2;
    assign same = ~diff;

`ifdef XNOR_GATE_MISMATCH_CNT_EN
    xnor_gate_popcount #(.WIDTH(WIDTH)) u_popcount (
        .bits  (diff),
        .count (diff_cnt)
    );
`else
    assign diff_cnt = '0;
`endif

    assign in_ready = (state == ST_EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = (state == ST_FULL) && out_ready;

    // Stage register: async clear drops any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            res   <= '0;
        end else begin
            state <= state_nxt;
            res   <= res_nxt;
        end
    end

    // Load on accept; a consume without a new accept only empties the stage, data holds.
    always_comb begin
        state_nxt = state;
        res_nxt   = res;
        if (accept) begin
            state_nxt            = ST_FULL;
            res_nxt.out1         = same;
            res_nxt.eq_all       = &same;
            res_nxt.mismatch_cnt = diff_cnt;
        end else if (consume) begin
            state_nxt = ST_EMPTY;
        end
    end

    assign out_valid    = (state == ST_FULL);
    assign out1         = res.out1;
    assign eq_all       = res.eq_all;
    assign mismatch_cnt = res.mismatch_cnt;

endmodule

// File: tb/tb_xnor_gate_unit.sv
// Directed bench for xnor_gate_unit at WIDTH=1 and WIDTH=8, with a per-cycle reference model.
module tb_xnor_gate_unit;

`ifdef XNOR_GATE_MISMATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;

    logic       rdy1, vld1, o1, eq1;
    logic [0:0] cnt1;
    logic       rdy8, vld8, eq8;
    logic [7:0] o8;
    logic [3:0] cnt8;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xnor_gate_unit #(.WIDTH(1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (rdy1),
        .in1          (a1),
        .in2          (b1),
        .out_valid    (vld1),
        .out_ready    (out_ready),
        .out1         (o1),
        .eq_all       (eq1),
        .mismatch_cnt (cnt1)
    );

    xnor_gate_unit #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (rdy8),
        .in1          (a8),
        .in2          (b8),
        .out_valid    (vld8),
        .out_ready    (out_ready),
        .out1         (o8),
        .eq_all       (eq8),
        .mismatch_cnt (cnt8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: holds the most recently accepted pair's result.
    logic       m1_v, m1_o, m1_e, m1_c;
    logic       m8_v, m8_e;
    logic [7:0] m8_o;
    logic [3:0] m8_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_v <= 0; m1_o <= 0; m1_e <= 0; m1_c <= 0;
        end else if (in_valid && (!m1_v || out_ready)) begin
            m1_v <= 1;
            m1_o <= (a1 == b1);
            m1_e <= (a1 == b1);
            m1_c <= CNT_EN ? (a1 != b1) : 1'b0;
        end else if (out_ready) begin
            m1_v <= 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_v <= 0; m8_o <= 0; m8_e <= 0; m8_c <= 0;
        end else if (in_valid && (!m8_v || out_ready)) begin
            m8_v <= 1;
            m8_o <= ~(a8 ^ b8);
            m8_e <= (a8 == b8);
            m8_c <= CNT_EN ? 4'($countones(a8 ^ b8)) : 4'd0;
        end else if (out_ready) begin
            m8_v <= 0;
        end
    end

    // Every cycle, away from the active edge, compare both DUTs against the model.
    always @(negedge clk) begin
        chk("w1_in_ready",  32'(rdy1), 32'(!m1_v || out_ready));
        chk("w1_out_valid", 32'(vld1), 32'(m1_v));
        chk("w1_out1",      32'(o1),   32'(m1_o));
        chk("w1_eq_all",    32'(eq1),  32'(m1_e));
        chk("w1_cnt",       32'(cnt1), 32'(m1_c));
        chk("w8_in_ready",  32'(rdy8), 32'(!m8_v || out_ready));
        chk("w8_out_valid", 32'(vld8), 32'(m8_v));
        chk("w8_out1",      32'(o8),   32'(m8_o));
        chk("w8_eq_all",    32'(eq8),  32'(m8_e));
        chk("w8_cnt",       32'(cnt8), 32'(m8_c));
    end

    // Drive away from the edge, then let one rising edge pass and settle.
    task automatic cyc(input logic v, input logic r, input logic x1, input logic y1,
                       input logic [7:0] x8, input logic [7:0] y8);
        @(negedge clk);
        #2;
        in_valid = v; out_ready = r;
        a1 = x1; b1 = y1; a8 = x8; b8 = y8;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_cnt_f0;
        exp_cnt_f0 = CNT_EN ? 4'd8 : 4'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(vld8), 32'd0);
        chk("rst_in_ready",  32'(rdy8), 32'd1);
        chk("rst_out1",      32'(o8),   32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // WIDTH=1 truth table at full throughput.
        cyc(1, 1, 0, 0, 8'hA5, 8'hA5);
        chk("tt00_out1", 32'(o1), 32'd1);
        chk("tt00_eq",   32'(eq1), 32'd1);
        chk("w8_a5_out1", 32'(o8), 32'hFF);
        chk("w8_a5_eq",   32'(eq8), 32'd1);
        chk("w8_a5_cnt",  32'(cnt8), 32'd0);
        cyc(1, 1, 1, 0, 8'hF0, 8'h0F);
        chk("tt10_out1", 32'(o1), 32'd0);
        chk("tt10_valid", 32'(vld1), 32'd1);
        chk("w8_f0_out1", 32'(o8), 32'h00);
        chk("w8_f0_eq",   32'(eq8), 32'd0);
        chk("w8_f0_cnt",  32'(cnt8), 32'(exp_cnt_f0));
        cyc(1, 1, 0, 1, 8'hFF, 8'h00);
        chk("tt01_out1", 32'(o1), 32'd0);
        chk("tt01_eq",   32'(eq1), 32'd0);
        chk("w8_ff00_out1", 32'(o8), 32'h00);
        cyc(1, 1, 1, 1, 8'h3C, 8'h3D);
        chk("tt11_out1", 32'(o1), 32'd1);
        chk("tt11_valid", 32'(vld1), 32'd1);
        chk("bp_load_out1", 32'(o8), 32'hFE);

        // Backpressure: stall three cycles while offering a different pair.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 1, 8'h00, 8'hFF);
            chk("bp_in_ready", 32'(rdy8), 32'd0);
            chk("bp_hold_out1", 32'(o8), 32'hFE);
            chk("bp_hold_valid", 32'(vld8), 32'd1);
        end
        cyc(1, 1, 0, 0, 8'h11, 8'h11);
        chk("bp_reload_out1", 32'(o8), 32'hFF);
        chk("bp_reload_valid", 32'(vld8), 32'd1);
        cyc(0, 1, 1, 0, 8'h00, 8'h00);
        chk("drain_valid", 32'(vld8), 32'd0);
        chk("drain_hold_out1", 32'(o8), 32'hFF);

        // Reset in the middle of a stall.
        cyc(1, 0, 0, 0, 8'h3C, 8'h3D);
        chk("pre_rst_out1", 32'(o8), 32'hFE);
        cyc(0, 0, 0, 0, 8'h00, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(vld8), 32'd0);
        chk("async_rst_out1",  32'(o8),   32'd0);
        chk("async_rst_eq",    32'(eq8),  32'd0);
        chk("async_rst_cnt",   32'(cnt8), 32'd0);
        chk("async_rst_ready", 32'(rdy8), 32'd1);
        chk("async_rst_w1",    32'(o1),   32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Random traffic with random backpressure, checked by the model.
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xnor_gate_unit.md
Name: xnor_gate_unit

Overview:
Registered, parameterizable bitwise XNOR (equality) unit with valid/ready handshake on both sides. Computes out1 = ~(in1 ^ in2) per bit, plus an all-bits-equal flag. Sits in datapaths as a pipelined bit-compare stage. WIDTH=1 gives the classic 2-input XNOR gate with one cycle of latency.

Parameters:
WIDTH, 1, operand and result width in bits (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  unit can accept an operand pair this cycle
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
out_valid  output  1  result registers hold an unconsumed result
out_ready  input  1  downstream accepts the result
out1  output  WIDTH  bitwise XNOR result, ~(in1 ^ in2)
eq_all  output  1  1 when in1 == in2 (AND-reduce of out1)
mismatch_cnt  output  $clog2(WIDTH+1)  number of differing bits (see Optional Feature)

Behaviour:
- Single-entry output register stage; latency 1 cycle from accept to out_valid.
- Accept = in_valid && in_ready. Output consume = out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational). Full throughput: accept and consume may happen in the same cycle.
- On accept: out1 <= ~(in1 ^ in2); eq_all <= &(~(in1 ^ in2)); mismatch_cnt <= popcount(in1 ^ in2); out_valid <= 1.
- On consume without accept: out_valid <= 0. out1, eq_all and mismatch_cnt hold their last values.
- Stall (out_valid && !out_ready): in_ready = 0. All outputs hold stable. in1/in2 are ignored.
- in_valid low: no register update. in1/in2 are don't-care.
- Reset (rst_n low, async assert, synchronous deassert handled by the system): out_valid=0, out1=0, eq_all=0, mismatch_cnt=0. in_ready therefore reads 1 during and after reset.
- Reset mid-stall discards the held result. There is no output glitch beyond the async clear.
- WIDTH=1 truth table for out1: 00->1, 01->0, 10->0, 11->1. For WIDTH=1, eq_all equals out1.

Optional Feature:
- XNOR_GATE_MISMATCH_CNT_EN defined: mismatch_cnt is registered on accept as popcount(in1 ^ in2). Range 0..WIDTH.
- XNOR_GATE_MISMATCH_CNT_EN undefined: mismatch_cnt is tied to 0 and the popcount logic is not instantiated.
- The port exists in both builds. out1, eq_all and the handshake are identical in both builds.

Decomposition:
- Package xnor_gate_pkg holds:
  - default WIDTH constant
  - function cnt_w(width) returning $clog2(width+1)
  - typedef for the handshake-stage state (valid bit plus result struct: out1, eq_all, mismatch_cnt)
- One sub-module, xnor_gate_popcount (parameter WIDTH): a combinational adder-tree bit count, instantiated only under XNOR_GATE_MISMATCH_CNT_EN.

Test Plan:
- WIDTH=1, out_ready=1, apply (in1,in2) = 00, 10, 01, 11 on consecutive cycles with in_valid=1 -> out1 one cycle later = 1, 0, 0, 1. out_valid is high every cycle after the first. eq_all matches out1.
- WIDTH=8, in1=8'hA5, in2=8'hA5 -> out1=8'hFF, eq_all=1, mismatch_cnt=0 (with macro). Then in1=8'hF0, in2=8'h0F -> out1=8'h00, eq_all=0, mismatch_cnt=8.
- Backpressure, WIDTH=8: accept 8'h3C vs 8'h3D, then hold out_ready=0 for 3 cycles -> in_ready=0. out1 holds 8'hFE and out_valid holds 1. New inputs are ignored. Raise out_ready -> consumed, and the next pair is accepted in the same cycle.
- Reset mid-operation: with out_valid=1 and out1=8'hFE, pulse rst_n low asynchronously between clock edges -> out_valid, out1, eq_all and mismatch_cnt go to 0 immediately, and in_ready reads 1.
- Build without XNOR_GATE_MISMATCH_CNT_EN, in1=8'hFF, in2=8'h00 -> mismatch_cnt=0, out1=8'h00, eq_all=0.
